program_sequencer: RTL
======================

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter LOG2_PROGRAM_SIZE, default 5: program BRAM address width; the program holds up to 2**LOG2_PROGRAM_SIZE instructions.
REQ-002 Parameter INSTR_WIDTH, default 512: width of one instruction word.
REQ-003 Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: single-cycle request to run a program; sampled only in IDLE.
REQ-006 Port prog_length, input, LOG2_PROGRAM_SIZE+1: instruction count, 0..2**LOG2_PROGRAM_SIZE; latched when start is accepted.
REQ-007 Port loop_count, input, 16: program repetitions minus one; latched when start is accepted.
REQ-008 Port prog_re, output, 1: program BRAM read request.
REQ-009 Port prog_raddr, output, LOG2_PROGRAM_SIZE: program BRAM read address.
REQ-010 Port prog_rdata, input, INSTR_WIDTH: program BRAM read data.
REQ-011 Port prog_rvalid, input, 1: prog_rdata is valid.
REQ-012 Port instr, output, INSTR_WIDTH: current decoded instruction; stable from DECODE through EXECUTE.
REQ-013 Port instr_valid, output, 1: one-cycle pulse that hands instr to the datapath.
REQ-014 Port exec_done, input, 1: datapath has finished the current instruction.
REQ-015 Port state, output, 3: current t_machinestate.
REQ-016 Port pc, output, LOG2_PROGRAM_SIZE: index of the current instruction.
REQ-017 Port done, output, 1: one-cycle pulse when the program completes.

Function
REQ-018 Registered FSM states: IDLE, INSTRUCTION_FETCH, INSTRUCTION_RECEIVE, INSTRUCTION_DECODE, EXECUTE, DONE. INSTRUCTION_FETCH and INSTRUCTION_RECEIVE are abbreviated FETCH and RECEIVE below.
REQ-019 IDLE transitions:
- start=1 and prog_length>0: go to FETCH, pc=0.
- start=1 and prog_length=0: go to DONE; no prog_re is issued.
REQ-020 FETCH: prog_re=1 for exactly one cycle with prog_raddr=pc, then go to RECEIVE.
REQ-021 RECEIVE: wait indefinitely for prog_rvalid=1, capture prog_rdata into instr, then go to DECODE.
REQ-022 prog_rvalid outside RECEIVE is ignored.
REQ-023 DECODE: lasts one cycle, then go to EXECUTE; instr_valid=1 in the first EXECUTE cycle only.
REQ-024 EXECUTE: exec_done is sampled every EXECUTE cycle, including the instr_valid cycle.
REQ-025 On exec_done in EXECUTE:
- pc<prog_length-1: pc increments, go to FETCH.
- pc=prog_length-1: end-of-program handling per REQ-036/REQ-037.
REQ-026 DONE lasts one cycle with done=1, then go to IDLE.
REQ-027 start is ignored outside IDLE; a start coincident with the DONE cycle is ignored.
REQ-028 Latency from an accepted start to prog_re is 1 cycle. Minimum instruction turnaround (FETCH to next FETCH) is 4 cycles plus BRAM latency plus datapath latency.
REQ-029 prog_length=2**LOG2_PROGRAM_SIZE executes every address; pc never wraps within one pass.

Reset
REQ-030 Reset may assert at any time, including mid-EXECUTE; it aborts the program immediately with no done pulse.
REQ-031 Reset values: state=IDLE, pc=0, prog_re=0, prog_raddr=0, instr=0, instr_valid=0, done=0, and the internal loop counter=0.

Configuration
REQ-032 Macro PIPEARCH_PROGRAM_LOOP_EN controls the program-loop feature.
REQ-033 With PIPEARCH_PROGRAM_LOOP_EN defined, loop_count is latched on start and controls repetition per REQ-036.
REQ-034 Without PIPEARCH_PROGRAM_LOOP_EN, loop_count is unused and the program runs once.

Structure
REQ-035 t_machinestate, LOG2_PROGRAM_SIZE and PROGRAM_SIZE come from the shared common package; no new shared typedefs are added.
REQ-036 With PIPEARCH_PROGRAM_LOOP_EN, at end of program:
- loop counter<latched loop_count: loop counter increments, pc=0, go to FETCH.
- otherwise: go to DONE.
REQ-037 Without PIPEARCH_PROGRAM_LOOP_EN, end of program always goes to DONE.
REQ-038 The block is flat: no sub-module; the pc and the loop counter are local registers.

Verification
REQ-039 prog_length=3, BRAM latency 1, exec_done 2 cycles after each instr_valid -> prog_raddr sequence 0,1,2; exactly 3 instr_valid pulses; one done pulse; state returns to IDLE.
REQ-040 prog_length=0 with start -> DONE on the next cycle, done pulse, prog_re never asserted.
REQ-041 exec_done held high continuously, prog_length=32 -> 32 instructions, pc reaches 31, no wrap, done pulse.
REQ-042 PIPEARCH_PROGRAM_LOOP_EN defined, prog_length=2, loop_count=2 -> 6 instr_valid pulses with addresses 0,1,0,1,0,1, then done; same stimulus without the macro -> 2 pulses.
REQ-043 Reset asserted in EXECUTE with pc=5 -> all outputs at reset values the same cycle, no done pulse; a later start runs from pc=0.
REQ-044 prog_rvalid pulsed while IDLE, and start pulsed during EXECUTE -> both ignored; pc, instr and state are unchanged.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program sequencer: program sizing and FSM state encoding.
package program_sequencer_pkg;

    localparam int LOG2_PROGRAM_SIZE = 5;
    localparam int PROGRAM_SIZE      = 2 ** LOG2_PROGRAM_SIZE;

    typedef enum logic [2:0] {
        IDLE                = 3'd0,
        INSTRUCTION_FETCH   = 3'd1,
        INSTRUCTION_RECEIVE = 3'd2,
        INSTRUCTION_DECODE  = 3'd3,
        EXECUTE             = 3'd4,
        DONE                = 3'd5
    } t_machinestate;

endpackage

// File: rtl/program_sequencer.sv
// Fetch/decode/execute sequencer that walks a program held in BRAM.
// Optional whole-program repetition is enabled by defining PIPEARCH_PROGRAM_LOOP_EN.
module program_sequencer #(
    parameter int LOG2_PROGRAM_SIZE = program_sequencer_pkg::LOG2_PROGRAM_SIZE,
    parameter int INSTR_WIDTH       = 512
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [LOG2_PROGRAM_SIZE:0]   prog_length,
    input  logic [15:0]                  loop_count,
    output logic                         prog_re,
    output logic [LOG2_PROGRAM_SIZE-1:0] prog_raddr,
    input  logic [INSTR_WIDTH-1:0]       prog_rdata,
    input  logic                         prog_rvalid,
    output logic [INSTR_WIDTH-1:0]       instr,
    output logic                         instr_valid,
    input  logic                         exec_done,
    output logic [2:0]                   state,
    output logic [LOG2_PROGRAM_SIZE-1:0] pc,
    output logic                         done
);
    import program_sequencer_pkg::*;

    t_machinestate                r_state, w_state_nxt;
    logic [LOG2_PROGRAM_SIZE-1:0] r_pc, w_pc_nxt;
    logic [LOG2_PROGRAM_SIZE:0]   r_len;
    logic [INSTR_WIDTH-1:0]       r_instr;
    logic                         r_instr_valid;
    logic                         w_start_acc;
    logic                         w_last;
    logic                         w_loop_inc;

`ifdef PIPEARCH_PROGRAM_LOOP_EN
    logic [15:0] r_loop_cnt;
    logic [15:0] r_loop_max;
`else
    logic w_unused;
    assign w_unused = ^loop_count;
`endif

    // r_len is never 0 once EXECUTE is reached, so len-1 cannot underflow here
    assign w_last = ({1'b0, r_pc} == (r_len - 1'b1));

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_start_acc = 1'b0;
        w_loop_inc  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_pc_nxt    = '0;
                    w_state_nxt = (prog_length == '0) ? DONE : INSTRUCTION_FETCH;
                end
            end
            INSTRUCTION_FETCH:   w_state_nxt = INSTRUCTION_RECEIVE;
            INSTRUCTION_RECEIVE: if (prog_rvalid) w_state_nxt = INSTRUCTION_DECODE;
            INSTRUCTION_DECODE:  w_state_nxt = EXECUTE;
            EXECUTE: begin
                if (exec_done) begin
                    if (!w_last) begin
                        w_pc_nxt    = r_pc + 1'b1;
                        w_state_nxt = INSTRUCTION_FETCH;
                    end else begin
`ifdef PIPEARCH_PROGRAM_LOOP_EN
                        if (r_loop_cnt < r_loop_max) begin
                            w_loop_inc  = 1'b1;
                            w_pc_nxt    = '0;
                            w_state_nxt = INSTRUCTION_FETCH;
                        end else begin
                            w_state_nxt = DONE;
                        end
`else
                        w_state_nxt = DONE;
`endif
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pc          <= '0;
            r_len         <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr_valid <= (r_state == INSTRUCTION_DECODE);
            if (w_start_acc)
                r_len <= prog_length;
            if (r_state == INSTRUCTION_RECEIVE && prog_rvalid)
                r_instr <= prog_rdata;
        end
    end

`ifdef PIPEARCH_PROGRAM_LOOP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_loop_cnt <= '0;
            r_loop_max <= '0;
        end else if (w_start_acc) begin
            r_loop_cnt <= '0;
            r_loop_max <= loop_count;
        end else if (w_loop_inc) begin
            r_loop_cnt <= r_loop_cnt + 16'd1;
        end
    end
`endif

    assign prog_re     = (r_state == INSTRUCTION_FETCH);
    assign prog_raddr  = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign state       = r_state;
    assign pc          = r_pc;
    assign done        = (r_state == DONE);

endmodule
